// File: rtl/stream_out_ctrl.sv
// Readout sequencer for the sign-bit buffer: waits out the counter pipeline,
// walks the sign vector out word by word and drives the downstream valid/last handshake.
module stream_out_ctrl #(
  parameter int DIM   = 1023,
  parameter int WORDS = (DIM + 1) / 32,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       last,
  input  logic       dst_ready,
  output logic       stream_v,
  output logic [4:0] stream_i,
  output logic       dst_valid,
  output logic       dst_last,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int         CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [4:0] LAST_IDX = 5'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [4:0]    idx_r, idx_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          dlast_r, dlast_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic          ovr_r, ovr_nxt_s;
  logic          issue_s;

  // Next-state, handshake and output-register logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    valid_nxt_s = valid_r;
    dlast_nxt_s = dlast_r;
    done_nxt_s  = 1'b0;
    ovr_nxt_s   = ovr_r;
    issue_s     = 1'b0;

    if (state_r == SEND) begin
      issue_s = !valid_r || dst_ready;
    end else begin
      issue_s = 1'b0;
    end

    // A held word is only replaced once accepted, so stream_d is never overwritten early.
    if (issue_s) begin
      valid_nxt_s = 1'b1;
      dlast_nxt_s = (idx_r == LAST_IDX);
    end else if (dst_ready) begin
      valid_nxt_s = 1'b0;
      dlast_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
      dlast_nxt_s = dlast_r;
    end

    if (last && (state_r != IDLE)) begin
      ovr_nxt_s = 1'b1;
    end else begin
      ovr_nxt_s = ovr_r;
    end

    case (state_r)
      IDLE: begin
        if (last) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = CW'(LAT - 1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == '0) begin
          state_nxt_s = SEND;
        end else begin
          cnt_nxt_s = cnt_r - 1'b1;
        end
      end
      SEND: begin
        if (issue_s) begin
          if (idx_r == LAST_IDX) begin
            idx_nxt_s   = 5'd0;
            state_nxt_s = DRAIN;
          end else begin
            idx_nxt_s = idx_r + 5'd1;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      DRAIN: begin
        if (valid_r && dst_ready && dlast_r) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 5'd0;
      valid_r <= 1'b0;
      dlast_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      valid_r <= valid_nxt_s;
      dlast_r <= dlast_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      ovr_r   <= ovr_nxt_s;
    end
  end

  assign stream_v  = issue_s;
  assign stream_i  = idx_r;
  assign dst_valid = valid_r;
  assign dst_last  = dlast_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign overrun   = ovr_r;

endmodule

// File: tb/tb_stream_out_ctrl.sv
// Scoreboard bench for stream_out_ctrl: a job model queues expected word indices,
// a negedge monitor checks accepted words, busy/done/overrun and issue latency.
module tb_stream_out_ctrl;

  localparam int LAT   = 2;
  localparam int WORDS = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       last;
  logic       dst_ready;
  logic       stream_v;
  logic [4:0] stream_i;
  logic       dst_valid;
  logic       dst_last;
  logic       busy;
  logic       done;
  logic       overrun;

  stream_out_ctrl #(.DIM(1023), .WORDS(WORDS), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .last(last), .dst_ready(dst_ready),
    .stream_v(stream_v), .stream_i(stream_i), .dst_valid(dst_valid),
    .dst_last(dst_last), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Emulated buffer: stream_d captures the issued index.
  logic [4:0] tb_d = 5'd0;
  always @(posedge clk) begin
    if (stream_v) tb_d <= stream_i;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state (updated by the monitor).
  int q[$];
  bit m_busy = 1'b0;
  bit m_ovr = 1'b0;
  bit m_done_exp = 1'b0;
  bit m_first = 1'b0;
  bit chk_zero = 1'b0;
  int cyc = 0;
  int m_last_cyc = 0;
  int m_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: samples on negedge, mid-cycle.
  initial begin
    int e;
    bit clr;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        q.delete();
        m_busy = 1'b0;
        m_ovr = 1'b0;
        m_done_exp = 1'b0;
        m_first = 1'b0;
        chk_zero = 1'b1;
      end else begin
        clr = 1'b0;
        if (chk_zero) begin
          check("reset_outputs", {21'd0, stream_v, stream_i, dst_valid, dst_last, busy, done, overrun}, 32'd0);
          chk_zero = 1'b0;
        end
        check("busy", busy, m_busy);
        check("overrun", overrun, m_ovr);
        check("done", done, m_done_exp);
        m_done_exp = 1'b0;
        if (dst_valid && !dst_ready) check("stall_no_issue", stream_v, 1'b0);
        if (!dst_valid && dst_last) check("last_without_valid", dst_last, 1'b0);
        if (m_busy && m_first && !stream_v) check("wait_index_zero", stream_i, 5'd0);
        if (stream_v && !m_busy) check("issue_when_idle", stream_v, 1'b0);
        if (stream_v && m_first) begin
          check("first_issue_latency", cyc - m_last_cyc, LAT + 1);
          m_first = 1'b0;
        end
        if (dst_valid && dst_ready) begin
          if (q.size() == 0) begin
            check("spurious_word", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("word_index", tb_d, e);
            check("word_last", dst_last, (e == WORDS - 1));
            if (e == WORDS - 1) begin
              clr = 1'b1;
              m_done_exp = 1'b1;
              m_done_cyc = cyc + 1;
            end
          end
        end
        if (last) begin
          if (m_busy) begin
            m_ovr = 1'b1;
          end else begin
            for (int i = 0; i < WORDS; i++) q.push_back(i);
            m_busy = 1'b1;
            m_last_cyc = cyc;
            m_first = 1'b1;
          end
        end
        if (clr) m_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n = 0;
    while ((m_busy || q.size() != 0) && n < 3000) begin
      if (rand_ready) dst_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (n >= 3000) check("idle_timeout", 32'd1, 32'd0);
    dst_ready = 1'b1;
    step();
    step();
  endtask

  // Issues last in the current cycle and returns with last cleared one cycle later.
  task automatic start_job();
    last = 1'b1;
    step();
    last = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    last = 1'b0;
    dst_ready = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    step();

    // Single job, dst_ready held high.
    start_job();
    wait_idle(1'b0);
    check("done_cycle_single", m_done_cyc - m_last_cyc, 32'd36);

    // Backpressure during relative cycles 6..9.
    last = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      last = 1'b0;
      dst_ready = !(k >= 6 && k <= 9);
    end
    dst_ready = 1'b1;
    wait_idle(1'b0);
    check("done_cycle_backpressure", m_done_cyc - m_last_cyc, 32'd40);

    // Back-to-back: second last in the done cycle (relative cycle 36).
    last = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      last = (k == 36);
    end
    step();
    last = 1'b0;
    wait_idle(1'b0);
    check("done_cycle_back_to_back", m_done_cyc - m_last_cyc, 32'd36);

    // Overrun: extra last at cycle 10 of a job.
    last = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      last = (k == 10);
    end
    last = 1'b0;
    wait_idle(1'b0);
    check("done_cycle_overrun", m_done_cyc - m_last_cyc, 32'd36);
    check("overrun_sticky", overrun, 1'b1);

    // Random dst_ready and occasional last pulses.
    for (int k = 0; k < 800; k++) begin
      dst_ready = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 49) == 0);
      step();
    end
    last = 1'b0;
    wait_idle(1'b1);

    // Reset at relative cycle 20, then a fresh job.
    last = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      last = 1'b0;
      rst = (k != 20);
    end
    repeat (40) step();
    check("overrun_after_reset", overrun, 1'b0);
    start_job();
    wait_idle(1'b0);
    check("done_cycle_after_reset", m_done_cyc - m_last_cyc, 32'd36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_out_ctrl.md
# stream_out_ctrl

Readout sequencer for the sign-bit buffer. After the cores finish accumulating, it waits out the counter pipeline latency. It then walks the 1024-bit sign vector out as 32 × 32-bit words by driving `stream_v`/`stream_i` into the buffer controller. It also generates the downstream valid/last handshake for the registered `stream_d` word, with full backpressure support. It sits between the core-completion logic and the output DMA stream.

## Interface
- `DIM`, 1023: hypervector MSB index; vector width is DIM+1, which must be a multiple of 32.
- `WORDS`, (DIM+1)/32 = 32: words per readout. `stream_i` width is fixed at 5 bits, so WORDS ≤ 32.
- `LAT`, 2: cycles from `last` until `sign_bit` is valid (the last_n → last_nn stages). Legal range is LAT ≥ 1.
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `last`, input, 1: single-cycle pulse marking the final core store of a job.
- `dst_ready`, input, 1: downstream accepts the current word.
- `stream_v`, output, 1: buffer controller latches word `stream_i` into `stream_d` on the next edge.
- `stream_i`, output, 5: word index, 0..WORDS-1.
- `dst_valid`, output, 1: `stream_d` holds a valid word.
- `dst_last`, output, 1: the current valid word is index WORDS-1.
- `busy`, output, 1: a readout is in progress.
- `done`, output, 1: one-cycle pulse after the final word is accepted.
- `overrun`, output, 1: sticky flag; `last` arrived while busy.

## Operation
- States are IDLE, WAIT, SEND and DRAIN. Reset (`rst`=0) forces IDLE, and all outputs are driven to 0, including `stream_i` and `overrun`.
- **IDLE**
  - `last`=1 → WAIT, with the wait counter loaded to LAT-1.
- **WAIT**
  - Decrement the counter; at 0 → SEND.
  - `stream_i` is held at 0.
- **SEND**
  - Issue condition: `issue = !dst_valid || dst_ready`.
  - `stream_v = issue` (combinational from state and the handshake).
  - On each issue, `stream_i` increments on the following edge.
  - Issue at index WORDS-1 → DRAIN, and `stream_i` wraps to 0.
- **DRAIN**
  - No issue.
  - When `dst_valid && dst_ready && dst_last` → IDLE, with `done`=1 for exactly that next cycle.
- **Output register**
  - `dst_valid <= issue ? 1 : (dst_ready ? 0 : dst_valid)`.
  - `dst_last <=` (issued index == WORDS-1) on issue; it clears with `dst_valid`.
- **Stall**
  - While `dst_valid && !dst_ready`: `stream_v`=0, and `stream_i`, `dst_valid` and `dst_last` hold.
  - As a result, `stream_d` in the buffer is never overwritten before it is accepted.
- `busy` = (state ≠ IDLE).
- **`last` while busy**
  - The pulse is ignored: no restart and no state change.
  - `overrun` is set and stays 1 until reset.
- **Back-to-back jobs:** a `last` in the same cycle as `done` is accepted, because the state is IDLE by then.
- **Reset mid-readout:** abort immediately, with no `done` pulse and `dst_valid` dropped.
- No word is skipped or duplicated under any pattern of `dst_ready`.

## Timing
- Latencies below use LAT=2, with `last` sampled high at cycle 0 and `dst_ready` held at 1:
  - WAIT occupies cycles 1–2.
  - SEND starts at cycle 3, with `stream_v`=1 and `stream_i`=0.
  - The first `dst_valid` is at cycle 4.
  - In general, the first `stream_v` is at cycle LAT+1 and the first `dst_valid` at LAT+2.
- **Throughput:** one word per cycle with no bubbles while `dst_ready`=1.
  - Index k is issued at cycle 3+k and is valid at cycle 4+k.
  - Index 31 is issued at cycle 34; `dst_valid` and `dst_last` are at cycle 35.
  - `done` is at cycle 36, when `busy` also drops.
- **Ready-low latency:** `dst_ready` low stalls the next issue with zero cycles of latency, since `issue` is combinational.
- **Ready-high latency:** re-asserting `dst_ready` lets an issue happen in that same cycle.
- `busy` rises in the cycle after `last` is sampled.

## Test plan
- **Single job, `dst_ready`=1:** `last` at cycle 0.
  - `stream_v` is high over cycles 3–34 with `stream_i` running 0..31.
  - `dst_valid` is high over cycles 4–35, with `dst_last` only at 35.
  - `done` at 36; `overrun`=0.
- **Backpressure:** `dst_ready`=0 during cycles 6–9.
  - Index 2 is held valid through cycle 9 and is accepted at cycle 10.
  - No `stream_v` during cycles 6–9; the final `dst_last` moves to cycle 39.
  - Exactly 32 accepted words, in order.
- **Random `dst_ready` at 50%:** accepted words have indices 0..31 strictly in order, and `dst_last` is set only on the 32nd word.
- **Overrun:** a second `last` at cycle 10 of a job → the readout completes unchanged and `overrun`=1 until `rst`=0.
- **Back-to-back:** `last` in the `done` cycle → a second full readout follows, with its first `stream_v` 3 cycles later.
- **Reset at cycle 20:** all outputs are 0 at cycle 21 and no `done`. A fresh `last` then produces a normal 32-word readout.
